dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port byte-addressed data memory (32 bytes, big-endian 32-bit word access, combinational read, write on clock falling edge).
- Shares the memory between port 0 (CPU load/store stage) and port 1 (test loader / DMA) using round-robin arbitration and a valid/ready request handshake.
- Registers the memory-side address, data and write-enable, checks alignment and range, and returns a one-cycle response pulse with read data or an error flag.

Parameters:
- MEM_BYTES, 32, data memory size in bytes; used for the range check.
- ADDR_W, 32, address width on both requester and memory sides.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- p0_req  in  1  port 0 request valid.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  ADDR_W  port 0 byte address.
- p0_wdata  in  32  port 0 write data.
- p0_ready  out  1  port 0 request accepted this cycle.
- p0_rvalid  out  1  port 0 response pulse.
- p0_rdata  out  32  port 0 read data.
- p0_err  out  1  port 0 response is an error.
- p1_*  same set as p0_*, for port 1.
- MemAddr  out  ADDR_W  to data memory.
- MemWriteData  out  32  to data memory.
- MemWrite  out  1  to data memory.
- MemReadData  in  32  from data memory.

Behaviour:
- Reset (async, rst_n=0):
  - MemAddr, MemWriteData, MemWrite cleared to 0.
  - p*_rvalid, p*_err and p*_rdata cleared to 0.
  - Round-robin pointer last_gnt set to 1, so port 0 wins the first conflict.
  - Pipeline stage set to invalid.
- Handshake:
  - A transfer occurs on a posedge where req=1 and ready=1.
  - ready is combinational from req and last_gnt.
  - The requester holds req, we, addr and wdata stable until ready.
  - ready is never asserted without req.
- Arbitration:
  - Only one requesting port: it is granted.
  - Both ports requesting: grant the port != last_gnt.
  - last_gnt updates on each transfer only.
  - At most one ready is high per cycle.
- Pipeline (1 stage, throughput 1 per cycle):
  - Cycle N, acceptance at posedge: MemAddr <= addr and MemWriteData <= wdata.
  - MemWrite <= we & legal; the memory writes at the negedge inside cycle N+1.
  - A stage register records the owner port, we and legal.
  - Posedge ending cycle N+1: owner's rvalid = 1 for exactly one cycle.
  - Legal read: rdata <= MemReadData.
  - Write: rdata <= 0.
  - Illegal access: rdata <= 0 and err <= 1.
  - The non-owner's rvalid stays 0.
  - A new request may be accepted in the same cycle as a response; back-to-back accesses are allowed.
- Legality:
  - addr[1:0]==0 and addr <= MEM_BYTES-4.
  - Illegal requests are still accepted (ready=1), so there is no deadlock; they never assert MemWrite.
- Idle:
  - No transfer means MemWrite <= 0; MemAddr and MemWriteData hold their last value.
  - No rvalid is produced the following cycle.
- Read-after-write:
  - Write at N followed by a read of the same address at N+1 returns the new data, because the write lands at the negedge before the read samples.
- Reset mid-operation:
  - In-flight response is dropped (rvalid forced 0).
  - MemWrite drops immediately; a write not yet past its negedge is lost.

Optional Feature:
- Macro: DM_ARB_STATS_EN.
- Defined:
  - Adds outputs p0_gnt_cnt[15:0], p1_gnt_cnt[15:0] and err_cnt[15:0].
  - Each counts transfers per port / illegal transfers; saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package dm_pkg:
  - MEM_BYTES constant.
  - Port-id typedef (PORT0=0, PORT1=1).
  - Response struct {valid, err, data}.
  - Function addr_legal(addr).
- One sub-module: dm_rr_arb2 (2-way round-robin grant with last_gnt register).
- Datapath and response staging stay in the top.

Test Plan:
- Port 0 writes 32'h11223344 to addr 8, then reads addr 8 → p0_rvalid one cycle after each transfer; read rdata=32'h11223344, err=0; byte at addr 8 = 8'h11.
- Both ports request continuously, reads to addrs 0/4, after reset → grants alternate 0,1,0,1; each p*_rvalid carries the correct data; never two readys in one cycle.
- Port 1 writes addr 6 (misaligned), then addr 32 (out of range) → ready=1, p1_err=1, rdata=0, MemWrite stays 0, memory unchanged.
- Back-to-back: write 32'hDEADBEEF at addr 12 in cycle N, read addr 12 in cycle N+1 → read response = 32'hDEADBEEF.
- Assert rst_n=0 while a write to addr 16 is in flight, before the negedge → MemWrite and rvalid go 0 immediately; addr 16 is unchanged; first conflict after reset grants port 0.
- With DM_ARB_STATS_EN: 3 port-0 transfers, 2 port-1 transfers and 1 illegal → p0_gnt_cnt=3, p1_gnt_cnt=2, err_cnt=1.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory arbiter: port ids, response
// record and the alignment/range legality check.
package dm_pkg;

  localparam int unsigned MEM_BYTES = 32'd32;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_id_t;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } dm_rsp_t;

  // A word access is legal when aligned and all four bytes fall inside memory.
  function automatic logic addr_legal(input logic [63:0] addr, input int unsigned mem_bytes);
    logic [63:0] lim;
    lim = 64'(mem_bytes) - 64'd4;
    return (addr[1:0] == 2'b00) && (addr <= lim);
  endfunction

endpackage

// File: rtl/dm_rr_arb2.sv
// Two-way round-robin grant; the port that did not win last time wins a tie.
module dm_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);
  import dm_pkg::*;

  port_id_t r_last_gnt;

  // Grant decode from requests and round-robin pointer
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (r_last_gnt == PORT1) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  // Pointer moves only when a grant turns into a transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt <= PORT1;
    end else if (o_gnt[0]) begin
      r_last_gnt <= PORT0;
    end else if (o_gnt[1]) begin
      r_last_gnt <= PORT1;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter and one-stage sequencer for the data memory.
// Optional per-port transfer / error counters under `DM_ARB_STATS_EN.
module dm_arbiter #(
  parameter int unsigned MEM_BYTES = 32'd32,
  parameter int unsigned ADDR_W    = 32'd32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_ready,
  output logic              p0_rvalid,
  output logic [31:0]       p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_ready,
  output logic              p1_rvalid,
  output logic [31:0]       p1_rdata,
  output logic              p1_err,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWriteData,
  output logic              MemWrite,
  input  logic [31:0]       MemReadData
`ifdef DM_ARB_STATS_EN
  ,
  output logic [15:0]       p0_gnt_cnt,
  output logic [15:0]       p1_gnt_cnt,
  output logic [15:0]       err_cnt
`endif
);
  import dm_pkg::*;

  logic [1:0]        w_gnt;
  logic              w_xfer;
  port_id_t          w_port;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic              w_legal;
  dm_rsp_t           w_rsp;

  logic              r_stg_valid;
  port_id_t          r_stg_port;
  logic              r_stg_we;
  logic              r_stg_legal;

  dm_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req ({p1_req, p0_req}),
    .o_gnt (w_gnt)
  );

  assign p0_ready = w_gnt[0];
  assign p1_ready = w_gnt[1];

  // Select the granted port's request fields
  always_comb begin
    w_xfer = w_gnt[0] | w_gnt[1];
    if (w_gnt[1]) begin
      w_port  = PORT1;
      w_we    = p1_we;
      w_addr  = p1_addr;
      w_wdata = p1_wdata;
    end else begin
      w_port  = PORT0;
      w_we    = p0_we;
      w_addr  = p0_addr;
      w_wdata = p0_wdata;
    end
    w_legal = addr_legal(64'(w_addr), MEM_BYTES);
  end

  // Memory-side registers and pipeline stage; illegal requests never write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MemAddr      <= '0;
      MemWriteData <= 32'h0;
      MemWrite     <= 1'b0;
      r_stg_valid  <= 1'b0;
      r_stg_port   <= PORT0;
      r_stg_we     <= 1'b0;
      r_stg_legal  <= 1'b0;
    end else begin
      r_stg_valid <= w_xfer;
      if (w_xfer) begin
        MemAddr      <= w_addr;
        MemWriteData <= w_wdata;
        MemWrite     <= w_we & w_legal;
        r_stg_port   <= w_port;
        r_stg_we     <= w_we;
        r_stg_legal  <= w_legal;
      end else begin
        MemWrite <= 1'b0;
      end
    end
  end

  // Response content for the staged access
  always_comb begin
    w_rsp.valid = r_stg_valid;
    w_rsp.err   = ~r_stg_legal;
    if (r_stg_legal && !r_stg_we) begin
      w_rsp.data = MemReadData;
    end else begin
      w_rsp.data = 32'h0;
    end
  end

  // Route the response pulse to the owning port; non-owner keeps its data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_rvalid <= 1'b0;
      p0_rdata  <= 32'h0;
      p0_err    <= 1'b0;
      p1_rvalid <= 1'b0;
      p1_rdata  <= 32'h0;
      p1_err    <= 1'b0;
    end else begin
      p0_rvalid <= w_rsp.valid && (r_stg_port == PORT0);
      p1_rvalid <= w_rsp.valid && (r_stg_port == PORT1);
      if (w_rsp.valid && (r_stg_port == PORT0)) begin
        p0_rdata <= w_rsp.data;
        p0_err   <= w_rsp.err;
      end
      if (w_rsp.valid && (r_stg_port == PORT1)) begin
        p1_rdata <= w_rsp.data;
        p1_err   <= w_rsp.err;
      end
    end
  end

`ifdef DM_ARB_STATS_EN
  logic [15:0] r_p0_cnt;
  logic [15:0] r_p1_cnt;
  logic [15:0] r_err_cnt;

  // Saturating transfer and error counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p0_cnt  <= 16'h0;
      r_p1_cnt  <= 16'h0;
      r_err_cnt <= 16'h0;
    end else begin
      if (w_gnt[0] && (r_p0_cnt != 16'hFFFF)) begin
        r_p0_cnt <= r_p0_cnt + 16'd1;
      end
      if (w_gnt[1] && (r_p1_cnt != 16'hFFFF)) begin
        r_p1_cnt <= r_p1_cnt + 16'd1;
      end
      if (w_xfer && !w_legal && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign p0_gnt_cnt = r_p0_cnt;
  assign p1_gnt_cnt = r_p1_cnt;
  assign err_cnt    = r_err_cnt;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter with a behavioural 32-byte big-endian memory.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [31:0] p0_addr = 32'h0, p0_wdata = 32'h0;
  logic        p0_ready, p0_rvalid, p0_err;
  logic [31:0] p0_rdata;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [31:0] p1_addr = 32'h0, p1_wdata = 32'h0;
  logic        p1_ready, p1_rvalid, p1_err;
  logic [31:0] p1_rdata;
  logic [31:0] MemAddr, MemWriteData, MemReadData;
  logic        MemWrite;
`ifdef DM_ARB_STATS_EN
  logic [15:0] p0_gnt_cnt, p1_gnt_cnt, err_cnt;
`endif

  dm_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ready(p0_ready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .MemAddr(MemAddr), .MemWriteData(MemWriteData), .MemWrite(MemWrite),
    .MemReadData(MemReadData)
`ifdef DM_ARB_STATS_EN
    , .p0_gnt_cnt(p0_gnt_cnt), .p1_gnt_cnt(p1_gnt_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0] mem [0:31];
  logic [7:0] ref_mem [0:31];

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb0[$];
  exp_t sb1[$];

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]     = 8'h40 + 8'(i);
      ref_mem[i] = 8'h40 + 8'(i);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: combinational big-endian read, write on falling edge
  always_comb begin
    int a;
    a = int'(MemAddr[4:0]);
    MemReadData = 32'h0;
    if (MemAddr <= 32'd28) MemReadData = {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  end

  always @(negedge clk) begin
    int a;
    a = int'(MemAddr[4:0]);
    if (MemWrite && MemAddr <= 32'd28) begin
      mem[a] <= MemWriteData[31:24]; mem[a+1] <= MemWriteData[23:16];
      mem[a+2] <= MemWriteData[15:8]; mem[a+3] <= MemWriteData[7:0];
    end
  end

  function automatic logic ref_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a <= 32'd28);
  endfunction

  function automatic exp_t mk_exp(input logic we, input logic [31:0] a);
    exp_t e;
    int   i;
    i = int'(a[4:0]);
    e.err  = ~ref_legal(a);
    e.data = 32'h0;
    e.due  = cyc + 2;
    if (ref_legal(a) && !we) e.data = {ref_mem[i], ref_mem[i+1], ref_mem[i+2], ref_mem[i+3]};
    return e;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
    int i;
    i = int'(a[4:0]);
    {ref_mem[i], ref_mem[i+1], ref_mem[i+2], ref_mem[i+3]} = d;
  endtask

  // Scoreboard: push on each accepted request, pop on each response pulse
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (p0_rvalid) begin
        n_cmp++;
        if (sb0.size() == 0) begin
          n_bad++;
          $display("FAIL p0_rsp: unexpected rvalid rdata=%h err=%b at cyc %0d", p0_rdata, p0_err, cyc);
        end else begin
          e = sb0.pop_front();
          if (p0_rdata !== e.data || p0_err !== e.err || cyc !== e.due) begin
            n_bad++;
            $display("FAIL p0_rsp: got rdata=%h err=%b cyc=%0d, expected rdata=%h err=%b cyc=%0d",
                     p0_rdata, p0_err, cyc, e.data, e.err, e.due);
          end
        end
      end
      if (p1_rvalid) begin
        n_cmp++;
        if (sb1.size() == 0) begin
          n_bad++;
          $display("FAIL p1_rsp: unexpected rvalid rdata=%h err=%b at cyc %0d", p1_rdata, p1_err, cyc);
        end else begin
          e = sb1.pop_front();
          if (p1_rdata !== e.data || p1_err !== e.err || cyc !== e.due) begin
            n_bad++;
            $display("FAIL p1_rsp: got rdata=%h err=%b cyc=%0d, expected rdata=%h err=%b cyc=%0d",
                     p1_rdata, p1_err, cyc, e.data, e.err, e.due);
          end
        end
      end
      if (p0_req && p0_ready) begin
        sb0.push_back(mk_exp(p0_we, p0_addr));
        if (p0_we && ref_legal(p0_addr)) ref_write(p0_addr, p0_wdata);
      end
      if (p1_req && p1_ready) begin
        sb1.push_back(mk_exp(p1_we, p1_addr));
        if (p1_we && ref_legal(p1_addr)) ref_write(p1_addr, p1_wdata);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted (bounded wait)
  task automatic xfer(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    bit got;
    got = 1'b0;
    if (p == 0) begin p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d; end
    else        begin p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d; end
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = (p == 0) ? p0_ready : p1_ready;
      if (!got) begin @(posedge clk); #1; end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL xfer_timeout: port %0d addr %h got no ready, expected ready within 20 cycles", p, a);
    end else begin
      @(posedge clk); #1;
    end
    if (p == 0) p0_req = 1'b0;
    else        p1_req = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle(2);
    n_cmp++;
    if ({MemAddr, MemWriteData, MemWrite} !== 65'h0) begin
      n_bad++;
      $display("FAIL reset_mem: got addr=%h wdata=%h we=%b, expected all 0", MemAddr, MemWriteData, MemWrite);
    end
    n_cmp++;
    if ({p0_rvalid, p0_err, p0_rdata, p1_rvalid, p1_err, p1_rdata} !== 68'h0) begin
      n_bad++;
      $display("FAIL reset_rsp: got p0 %b/%b/%h p1 %b/%b/%h, expected all 0",
               p0_rvalid, p0_err, p0_rdata, p1_rvalid, p1_err, p1_rdata);
    end
    n_cmp++;
    if ({p1_ready, p0_ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_ready: got %b, expected 00 without requests", {p1_ready, p0_ready});
    end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_conflict;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'd0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'd4;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({p1_ready, p0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_bad++;
        $display("FAIL rr_order[%0d]: got ready=%b, expected %b", i, {p1_ready, p0_ready},
                 (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      @(posedge clk); #1;
      p0_addr = (i < 2) ? 32'd0 : 32'd8;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    idle(3);
  endtask

  task automatic test_write_read;
    xfer(0, 1'b1, 32'd8, 32'h11223344);
    xfer(0, 1'b0, 32'd8, 32'h0);
    idle(3);
    n_cmp++;
    if ({mem[8], mem[9], mem[10], mem[11]} !== 32'h11223344) begin
      n_bad++;
      $display("FAIL wr_bytes: got %h %h %h %h, expected 11 22 33 44", mem[8], mem[9], mem[10], mem[11]);
    end
  endtask

  task automatic test_illegal;
    logic [95:0] snap;
    snap = {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6], mem[7], mem[8], mem[9], mem[10], mem[11]};
    xfer(1, 1'b1, 32'd6, 32'hA5A5A5A5);
    n_cmp++;
    if (MemWrite !== 1'b0) begin
      n_bad++; $display("FAIL ill_misaligned_we: got MemWrite=%b, expected 0", MemWrite);
    end
    xfer(1, 1'b1, 32'd32, 32'h5A5A5A5A);
    n_cmp++;
    if (MemWrite !== 1'b0) begin
      n_bad++; $display("FAIL ill_range_we: got MemWrite=%b, expected 0", MemWrite);
    end
    xfer(1, 1'b0, 32'd28, 32'h0);
    idle(3);
    n_cmp++;
    if ({mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6], mem[7], mem[8], mem[9], mem[10], mem[11]} !== snap) begin
      n_bad++; $display("FAIL ill_mem: got %h, expected %h",
        {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6], mem[7], mem[8], mem[9], mem[10], mem[11]}, snap);
    end
  endtask

  task automatic test_back_to_back;
    xfer(0, 1'b1, 32'd12, 32'hDEADBEEF);
    xfer(0, 1'b0, 32'd12, 32'h0);
    xfer(1, 1'b1, 32'd24, 32'h0BADF00D);
    xfer(1, 1'b0, 32'd24, 32'h0);
    idle(3);
  endtask

  task automatic test_reset_midop;
    logic [31:0] saved;
    saved = {mem[16], mem[17], mem[18], mem[19]};
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'd16; p0_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    p0_req = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({MemWrite, p0_rvalid, p1_rvalid} !== 3'b000) begin
      n_bad++;
      $display("FAIL midrst_drop: got MemWrite=%b p0_rvalid=%b p1_rvalid=%b, expected 000",
               MemWrite, p0_rvalid, p1_rvalid);
    end
    idle(2);
    n_cmp++;
    if ({mem[16], mem[17], mem[18], mem[19]} !== saved) begin
      n_bad++;
      $display("FAIL midrst_mem: got %h, expected %h", {mem[16], mem[17], mem[18], mem[19]}, saved);
    end
    {ref_mem[16], ref_mem[17], ref_mem[18], ref_mem[19]} = saved;
    sb0.delete(); sb1.delete();
    rst_n = 1'b1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'd16;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'd20;
    @(negedge clk);
    n_cmp++;
    if ({p1_ready, p0_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL midrst_first_gnt: got ready=%b, expected 01", {p1_ready, p0_ready});
    end
    @(posedge clk); #1;
    p0_req = 1'b0; p1_req = 1'b0;
    idle(3);
  endtask

`ifdef DM_ARB_STATS_EN
  task automatic test_stats;
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    xfer(0, 1'b0, 32'd0, 32'h0);
    xfer(0, 1'b1, 32'd20, 32'h01020304);
    xfer(0, 1'b0, 32'd20, 32'h0);
    xfer(1, 1'b0, 32'd4, 32'h0);
    xfer(1, 1'b1, 32'd30, 32'hFFFFFFFF);
    idle(3);
    n_cmp++;
    if ({p0_gnt_cnt, p1_gnt_cnt, err_cnt} !== {16'd3, 16'd2, 16'd1}) begin
      n_bad++;
      $display("FAIL stats: got p0=%0d p1=%0d err=%0d, expected 3 2 1", p0_gnt_cnt, p1_gnt_cnt, err_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_conflict();
    test_write_read();
    test_illegal();
    test_back_to_back();
    test_reset_midop();
`ifdef DM_ARB_STATS_EN
    test_stats();
`endif
    n_cmp++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d/%0d responses outstanding, expected 0/0", sb0.size(), sb1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
